uart_packet_rx: RTL

Byte-stream deframer that sits directly downstream of the UART receiver. It consumes the receiver's `opRxData`/`opRxValid` byte strobes and parses framed packets of the form sync (0x55), destination, length, payload. Payload bytes are emitted as a strobed stream with start/end-of-packet markers and the packet header held stable, for the register/stream logic behind it.

---
 rtl/uart_packet_rx.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_packet_rx.sv
// uart_packet_rx -- byte-stream deframer downstream of the UART receiver.
//
// Parses packets: sync (0x55), destination, length (0 means 256), payload.
// Payload bytes are re-emitted one clock after their input strobe, with
// start/end-of-packet markers; destination and length are held until the
// next header.
//
// Optional feature: define UART_PACKET_RX_TIMEOUT_EN to abort a packet whose
// inter-byte gap reaches TIMEOUT_CYCLES clocks (pulses opTimeout). Without
// the macro, opTimeout is tied 0 and a truncated packet waits indefinitely.
//
// Ports:
//   ipClk, ipReset        clock, async active-high reset
//   ipRxData, ipRxValid   received byte + single-cycle strobe
//   opDestination         destination byte of current packet
//   opLength              payload length 1..256
//   opData, opValid       payload byte + strobe
//   opSoP, opEoP          first / last payload byte markers (with opValid)
//   opTimeout             1-cycle pulse on timeout abort
module uart_packet_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 43400
) (
  input  logic       ipClk,
  input  logic       ipReset,
  input  logic [7:0] ipRxData,
  input  logic       ipRxValid,
  output logic [7:0] opDestination,
  output logic [8:0] opLength,
  output logic [7:0] opData,
  output logic       opValid,
  output logic       opSoP,
  output logic       opEoP,
  output logic       opTimeout
);

  typedef enum logic [1:0] {IDLE, GET_DEST, GET_LEN, GET_DATA} state_t;

  state_t     state;
  logic [8:0] cnt;     // payload bytes still expected
  logic [8:0] len_dec; // length byte with 0 decoded as 256

  assign len_dec = (ipRxData == 8'h00) ? 9'd256 : {1'b0, ipRxData};

`ifdef UART_PACKET_RX_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  logic [GW-1:0] gap;
  logic          expire;

  // gap counts clocks since the last strobe; a strobe landing on the
  // expiry cycle wins, so the byte is processed and nothing is aborted.
  assign expire = (state != IDLE) && !ipRxValid &&
                  (gap == GW'(TIMEOUT_CYCLES - 1));
`else
  assign opTimeout = 1'b0;
`endif

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state         <= IDLE;
      cnt           <= '0;
      opDestination <= '0;
      opLength      <= '0;
      opData        <= '0;
      opValid       <= 1'b0;
      opSoP         <= 1'b0;
      opEoP         <= 1'b0;
`ifdef UART_PACKET_RX_TIMEOUT_EN
      gap           <= '0;
      opTimeout     <= 1'b0;
`endif
    end else begin
      opValid <= 1'b0;
      opSoP   <= 1'b0;
      opEoP   <= 1'b0;
`ifdef UART_PACKET_RX_TIMEOUT_EN
      opTimeout <= 1'b0;
      if (state == IDLE || ipRxValid) gap <= '0;
      else                            gap <= gap + 1'b1;
      if (expire) begin
        state     <= IDLE;
        cnt       <= '0;
        opTimeout <= 1'b1;
      end else
`endif
      if (ipRxValid) begin
        case (state)
          IDLE: if (ipRxData == 8'h55) state <= GET_DEST;
          GET_DEST: begin
            opDestination <= ipRxData;
            state         <= GET_LEN;
          end
          GET_LEN: begin
            opLength <= len_dec;
            cnt      <= len_dec;
            state    <= GET_DATA;
          end
          GET_DATA: begin
            // 0x55 here is plain payload, never a resync
            opData  <= ipRxData;
            opValid <= 1'b1;
            opSoP   <= (cnt == opLength);
            opEoP   <= (cnt == 9'd1);
            cnt     <= cnt - 9'd1;
            if (cnt == 9'd1) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
